// File: rtl/move_validator_fsm_pkg.sv
// Shared encodings for the tic-tac-toe move validator: cell codes, reject reasons, FSM states.
package ttt_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_PL    = 2'b01;
    localparam logic [1:0] CELL_PC    = 2'b10;

    localparam logic [2:0] ILL_NONE = 3'd0;
    localparam logic [2:0] ILL_ENC  = 3'd1;
    localparam logic [2:0] ILL_OCC  = 3'd2;
    localparam logic [2:0] ILL_TURN = 3'd3;
    localparam logic [2:0] ILL_COLL = 3'd4;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CHECK  = 3'd1;
    localparam logic [2:0] ST_COMMIT = 3'd2;
    localparam logic [2:0] ST_REJECT = 3'd3;
    localparam logic [2:0] ST_FULL   = 3'd4;

endpackage

// File: rtl/move_validator_fsm_if.sv
// Player/computer move request handshake bundle; master drives requests, slave returns readys.
interface move_validator_fsm_if #(
    parameter int CELLS = 16
) ();

    logic             pl_valid;
    logic [CELLS-1:0] pl_en;
    logic             pl_ready;
    logic             pc_valid;
    logic [CELLS-1:0] pc_en;
    logic             pc_ready;

    modport master (
        output pl_valid, pl_en, pc_valid, pc_en,
        input  pl_ready, pc_ready
    );

    modport slave (
        input  pl_valid, pl_en, pc_valid, pc_en,
        output pl_ready, pc_ready
    );

endinterface

// File: rtl/move_validator_fsm_onehot.sv
// Combinational one-hot check and binary index of the set bit of a cell-select vector.
module onehot_index #(
    parameter  int CELLS = 16,
    localparam int IDX_W = $clog2(CELLS)
) (
    input  logic [CELLS-1:0] en_i,
    output logic             is_onehot_o,
    output logic [IDX_W-1:0] index_o
);

    assign is_onehot_o = (en_i != '0) && ((en_i & (en_i - CELLS'(1))) == '0);

    // OR of set-bit positions; exact whenever the input is one-hot.
    always_comb begin
        index_o = '0;
        for (int i = 0; i < CELLS; i++) begin
            if (en_i[i]) begin
                index_o = index_o | IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/move_validator_fsm.sv
// Tic-tac-toe move validator: latches a move, checks it, then commits it or reports a reason.
// Define MOVE_VALIDATOR_ILLEGAL_CNT_EN to add the saturating illegal_cnt output.
module move_validator_fsm
    import ttt_pkg::*;
#(
    parameter int BOARD_DIM = 4,
    parameter bit FIRST_PC  = 1'b0
`ifdef MOVE_VALIDATOR_ILLEGAL_CNT_EN
    ,
    parameter int CNT_W     = 8
`endif
) (
    input  logic                                    clock,
    input  logic                                    reset_n,
    input  logic                                    clear,
    move_validator_fsm_if.slave                     mv,
    output logic [2*BOARD_DIM*BOARD_DIM-1:0]        board,
    output logic                                    turn,
    output logic                                    move_ok,
    output logic                                    illegal_move,
    output logic [2:0]                              illegal_code,
    output logic [$clog2(BOARD_DIM*BOARD_DIM+1)-1:0] move_count,
    output logic                                    board_full
`ifdef MOVE_VALIDATOR_ILLEGAL_CNT_EN
    ,
    output logic [CNT_W-1:0]                        illegal_cnt
`endif
);

    localparam int CELLS = BOARD_DIM * BOARD_DIM;
    localparam int MC_W  = $clog2(CELLS + 1);
    localparam int IDX_W = $clog2(CELLS);
    localparam logic [MC_W-1:0] CNT_FULL = MC_W'(CELLS);

    logic [2:0]       state_q, state_d;
    logic [2*CELLS-1:0] board_q, board_d;
    logic             turn_q, turn_d;
    logic [MC_W-1:0]  count_q, count_d;
    logic             full_q, full_d;
    logic             move_ok_q, move_ok_d;
    logic             illegal_q, illegal_d;
    logic [2:0]       code_q, code_d;
    logic             req_pl_valid_q, req_pl_valid_d;
    logic             req_pc_valid_q, req_pc_valid_d;
    logic [CELLS-1:0] req_pl_en_q, req_pl_en_d;
    logic [CELLS-1:0] req_pc_en_q, req_pc_en_d;
    logic [2:0]       chk_code_q, chk_code_d;
    logic [IDX_W-1:0] chk_idx_q, chk_idx_d;
    logic             chk_pc_q, chk_pc_d;

    logic             mover_pc;
    logic [CELLS-1:0] mover_en;
    logic             is_onehot;
    logic [IDX_W-1:0] mover_idx;
    logic [2:0]       check_code;

    // On a collision the mover choice is irrelevant because the request is rejected anyway.
    assign mover_pc = ~req_pl_valid_q;
    assign mover_en = mover_pc ? req_pc_en_q : req_pl_en_q;

    onehot_index #(
        .CELLS (CELLS)
    ) u_onehot (
        .en_i        (mover_en),
        .is_onehot_o (is_onehot),
        .index_o     (mover_idx)
    );

    always_comb begin
        check_code = ILL_NONE;
        if (req_pl_valid_q && req_pc_valid_q) begin
            check_code = ILL_COLL;
        end else if (mover_pc != turn_q) begin
            check_code = ILL_TURN;
        end else if (!is_onehot) begin
            check_code = ILL_ENC;
        end else if (board_q[{mover_idx, 1'b0} +: 2] != CELL_EMPTY) begin
            check_code = ILL_OCC;
        end
    end

    always_comb begin
        state_d        = state_q;
        board_d        = board_q;
        turn_d         = turn_q;
        count_d        = count_q;
        move_ok_d      = 1'b0;
        illegal_d      = 1'b0;
        code_d         = ILL_NONE;
        req_pl_valid_d = req_pl_valid_q;
        req_pc_valid_d = req_pc_valid_q;
        req_pl_en_d    = req_pl_en_q;
        req_pc_en_d    = req_pc_en_q;
        chk_code_d     = chk_code_q;
        chk_idx_d      = chk_idx_q;
        chk_pc_d       = chk_pc_q;

        if (clear) begin
            state_d        = ST_IDLE;
            board_d        = '0;
            turn_d         = FIRST_PC;
            count_d        = '0;
            req_pl_valid_d = 1'b0;
            req_pc_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mv.pl_valid || mv.pc_valid) begin
                        req_pl_valid_d = mv.pl_valid;
                        req_pc_valid_d = mv.pc_valid;
                        req_pl_en_d    = mv.pl_en;
                        req_pc_en_d    = mv.pc_en;
                        state_d        = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    chk_code_d = check_code;
                    chk_idx_d  = mover_idx;
                    chk_pc_d   = mover_pc;
                    state_d    = (check_code == ILL_NONE) ? ST_COMMIT : ST_REJECT;
                end
                ST_COMMIT: begin
                    board_d[{chk_idx_q, 1'b0} +: 2] = chk_pc_q ? CELL_PC : CELL_PL;
                    turn_d    = ~turn_q;
                    if (count_q != CNT_FULL) begin
                        count_d = count_q + MC_W'(1);
                    end
                    move_ok_d = 1'b1;
                    state_d   = (count_d == CNT_FULL) ? ST_FULL : ST_IDLE;
                end
                ST_REJECT: begin
                    illegal_d = 1'b1;
                    code_d    = chk_code_q;
                    state_d   = ST_IDLE;
                end
                ST_FULL: begin
                    state_d = ST_FULL;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        full_d = (count_d == CNT_FULL);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            board_q        <= '0;
            turn_q         <= FIRST_PC;
            count_q        <= '0;
            full_q         <= 1'b0;
            move_ok_q      <= 1'b0;
            illegal_q      <= 1'b0;
            code_q         <= ILL_NONE;
            req_pl_valid_q <= 1'b0;
            req_pc_valid_q <= 1'b0;
            req_pl_en_q    <= '0;
            req_pc_en_q    <= '0;
            chk_code_q     <= ILL_NONE;
            chk_idx_q      <= '0;
            chk_pc_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            board_q        <= board_d;
            turn_q         <= turn_d;
            count_q        <= count_d;
            full_q         <= full_d;
            move_ok_q      <= move_ok_d;
            illegal_q      <= illegal_d;
            code_q         <= code_d;
            req_pl_valid_q <= req_pl_valid_d;
            req_pc_valid_q <= req_pc_valid_d;
            req_pl_en_q    <= req_pl_en_d;
            req_pc_en_q    <= req_pc_en_d;
            chk_code_q     <= chk_code_d;
            chk_idx_q      <= chk_idx_d;
            chk_pc_q       <= chk_pc_d;
        end
    end

`ifdef MOVE_VALIDATOR_ILLEGAL_CNT_EN
    logic [CNT_W-1:0] ill_cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ill_cnt_q <= '0;
        end else if (clear) begin
            ill_cnt_q <= '0;
        end else if (state_q == ST_REJECT && ill_cnt_q != '1) begin
            ill_cnt_q <= ill_cnt_q + CNT_W'(1);
        end
    end

    assign illegal_cnt = ill_cnt_q;
`endif

    // Readys decode state only so there is no combinational path from the valids.
    assign mv.pl_ready  = (state_q == ST_IDLE);
    assign mv.pc_ready  = (state_q == ST_IDLE);

    assign board        = board_q;
    assign turn         = turn_q;
    assign move_ok      = move_ok_q;
    assign illegal_move = illegal_q;
    assign illegal_code = code_q;
    assign move_count   = count_q;
    assign board_full   = full_q;

endmodule

// File: tb/tb_move_validator_fsm.sv
// Self-checking bench for move_validator_fsm (4x4 board, player first); vector table plus scoreboard.
module tb_move_validator_fsm;

    localparam int CELLS = 16;

    typedef struct {
        logic        plv;
        logic [15:0] ple;
        logic        pcv;
        logic [15:0] pce;
        logic        ok;
        logic [2:0]  code;
        logic [31:0] board;
        logic        turn;
        logic [4:0]  cnt;
    } vec_t;

    typedef struct {
        logic        ok;
        logic [2:0]  code;
        logic [31:0] board;
        logic        turn;
        logic [4:0]  cnt;
        logic        full;
        int          acc;
    } exp_t;

    logic        clock;
    logic        reset_n;
    logic        clear;
    logic [31:0] board;
    logic        turn;
    logic        move_ok;
    logic        illegal_move;
    logic [2:0]  illegal_code;
    logic [4:0]  move_count;
    logic        board_full;
`ifdef MOVE_VALIDATOR_ILLEGAL_CNT_EN
    logic [7:0]  illegal_cnt;
    int          tbIllCnt = 0;
`endif

    exp_t        sbq[$];
    exp_t        monE;
    vec_t        vecs[14];
    int          cyc = 0;
    int          passCnt = 0;
    int          totalCnt = 0;

    move_validator_fsm_if #(.CELLS(CELLS)) mv ();

    move_validator_fsm #(
        .BOARD_DIM (4),
        .FIRST_PC  (1'b0)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .clear        (clear),
        .mv           (mv),
        .board        (board),
        .turn         (turn),
        .move_ok      (move_ok),
        .illegal_move (illegal_move),
        .illegal_code (illegal_code),
        .move_count   (move_count),
        .board_full   (board_full)
`ifdef MOVE_VALIDATOR_ILLEGAL_CNT_EN
        ,
        .illegal_cnt  (illegal_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) begin
            passCnt++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard consumer: every result pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (move_ok || illegal_move) begin
            if (sbq.size() == 0) begin
                checkOutput("unexpected_pulse", 32'(move_ok | illegal_move), 32'd0);
            end else begin
                monE = sbq.pop_front();
                checkOutput("pulse_latency", 32'(cyc - monE.acc), 32'd2);
                checkOutput("move_ok", 32'(move_ok), 32'(monE.ok));
                checkOutput("illegal_move", 32'(illegal_move), 32'(!monE.ok));
                checkOutput("illegal_code", 32'(illegal_code), 32'(monE.code));
                checkOutput("board", board, monE.board);
                checkOutput("turn", 32'(turn), 32'(monE.turn));
                checkOutput("move_count", 32'(move_count), 32'(monE.cnt));
                checkOutput("board_full", 32'(board_full), 32'(monE.full));
`ifdef MOVE_VALIDATOR_ILLEGAL_CNT_EN
                if (!monE.ok) tbIllCnt++;
                checkOutput("illegal_cnt", 32'(illegal_cnt), 32'(tbIllCnt));
`endif
            end
        end
    end

    task automatic applyStimulus(input vec_t v, input logic expFull);
        exp_t e;
        bit   gotReady;
        @(negedge clock);
        mv.pl_valid = v.plv;
        mv.pl_en    = v.ple;
        mv.pc_valid = v.pcv;
        mv.pc_en    = v.pce;
        gotReady    = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if ((!v.plv || mv.pl_ready) && (!v.pcv || mv.pc_ready)) begin
                gotReady = 1'b1;
                break;
            end
            @(negedge clock);
        end
        checkOutput("ready_before_accept", 32'(gotReady), 32'd1);
        if (gotReady) begin
            @(posedge clock);
            @(negedge clock);
            e.ok    = v.ok;
            e.code  = v.code;
            e.board = v.board;
            e.turn  = v.turn;
            e.cnt   = v.cnt;
            e.full  = expFull;
            e.acc   = cyc;
            sbq.push_back(e);
        end
        mv.pl_valid = 1'b0;
        mv.pl_en    = '0;
        mv.pc_valid = 1'b0;
        mv.pc_en    = '0;
        repeat (3) @(negedge clock);
        #1;
        checkOutput("pulse_seen", 32'(sbq.size()), 32'd0);
        sbq.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t        v;
        logic [31:0] modelBoard;

        reset_n     = 1'b0;
        clear       = 1'b0;
        mv.pl_valid = 1'b0;
        mv.pl_en    = '0;
        mv.pc_valid = 1'b0;
        mv.pc_en    = '0;

        //              plv  ple       pcv  pce       ok    code  board          turn  cnt
        vecs[0]  = '{1'b1, 16'h0001, 1'b0, 16'h0000, 1'b1, 3'd0, 32'h0000_0001, 1'b1, 5'd1};
        vecs[1]  = '{1'b1, 16'h0002, 1'b0, 16'h0000, 1'b0, 3'd3, 32'h0000_0001, 1'b1, 5'd1};
        vecs[2]  = '{1'b0, 16'h0000, 1'b1, 16'h0001, 1'b0, 3'd2, 32'h0000_0001, 1'b1, 5'd1};
        vecs[3]  = '{1'b0, 16'h0000, 1'b1, 16'h8000, 1'b1, 3'd0, 32'h8000_0001, 1'b0, 5'd2};
        vecs[4]  = '{1'b0, 16'h0000, 1'b1, 16'h0002, 1'b0, 3'd3, 32'h8000_0001, 1'b0, 5'd2};
        vecs[5]  = '{1'b1, 16'h0003, 1'b0, 16'h0000, 1'b0, 3'd1, 32'h8000_0001, 1'b0, 5'd2};
        vecs[6]  = '{1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, 3'd1, 32'h8000_0001, 1'b0, 5'd2};
        vecs[7]  = '{1'b1, 16'h0002, 1'b1, 16'h0004, 1'b0, 3'd4, 32'h8000_0001, 1'b0, 5'd2};
        vecs[8]  = '{1'b1, 16'h0002, 1'b0, 16'h0000, 1'b1, 3'd0, 32'h8000_0005, 1'b1, 5'd3};
        vecs[9]  = '{1'b0, 16'h0000, 1'b1, 16'h0002, 1'b0, 3'd2, 32'h8000_0005, 1'b1, 5'd3};
        vecs[10] = '{1'b0, 16'h0000, 1'b1, 16'h0004, 1'b1, 3'd0, 32'h8000_0025, 1'b0, 5'd4};
        vecs[11] = '{1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 3'd3, 32'h8000_0025, 1'b0, 5'd4};
        vecs[12] = '{1'b1, 16'h8000, 1'b0, 16'h0000, 1'b0, 3'd2, 32'h8000_0025, 1'b0, 5'd4};
        vecs[13] = '{1'b1, 16'h0100, 1'b0, 16'h0000, 1'b1, 3'd0, 32'h8001_0025, 1'b1, 5'd5};

        repeat (2) @(negedge clock);
        checkOutput("in_reset_board", board, 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        checkOutput("rst_board", board, 32'd0);
        checkOutput("rst_turn", 32'(turn), 32'd0);
        checkOutput("rst_move_count", 32'(move_count), 32'd0);
        checkOutput("rst_move_ok", 32'(move_ok), 32'd0);
        checkOutput("rst_illegal_move", 32'(illegal_move), 32'd0);
        checkOutput("rst_illegal_code", 32'(illegal_code), 32'd0);
        checkOutput("rst_board_full", 32'(board_full), 32'd0);
        checkOutput("rst_pl_ready", 32'(mv.pl_ready), 32'd1);
        checkOutput("rst_pc_ready", 32'(mv.pc_ready), 32'd1);

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i], 1'b0);
        end

        // Request latched, then clear arrives while it is being checked: it must vanish silently.
        @(negedge clock);
        mv.pc_valid = 1'b1;
        mv.pc_en    = 16'h0010;
        checkOutput("clr_pc_ready", 32'(mv.pc_ready), 32'd1);
        @(posedge clock);
        @(negedge clock);
        mv.pc_valid = 1'b0;
        mv.pc_en    = '0;
        clear       = 1'b1;
        @(negedge clock);
        clear = 1'b0;
`ifdef MOVE_VALIDATOR_ILLEGAL_CNT_EN
        tbIllCnt = 0;
`endif
        repeat (3) @(negedge clock);
        checkOutput("clr_board", board, 32'd0);
        checkOutput("clr_move_count", 32'(move_count), 32'd0);
        checkOutput("clr_turn", 32'(turn), 32'd0);
        checkOutput("clr_board_full", 32'(board_full), 32'd0);
        checkOutput("clr_pl_ready", 32'(mv.pl_ready), 32'd1);
`ifdef MOVE_VALIDATOR_ILLEGAL_CNT_EN
        checkOutput("clr_illegal_cnt", 32'(illegal_cnt), 32'd0);
`endif

        modelBoard = '0;
        for (int i = 0; i < CELLS; i++) begin
            v.plv = (i % 2 == 0);
            v.pcv = !v.plv;
            v.ple = v.plv ? (16'h0001 << i) : 16'h0000;
            v.pce = v.pcv ? (16'h0001 << i) : 16'h0000;
            modelBoard[2*i +: 2] = v.plv ? 2'b01 : 2'b10;
            v.ok    = 1'b1;
            v.code  = 3'd0;
            v.board = modelBoard;
            v.turn  = v.plv;
            v.cnt   = 5'(i + 1);
            applyStimulus(v, (i == CELLS - 1));
        end

        @(negedge clock);
        checkOutput("full_flag", 32'(board_full), 32'd1);
        checkOutput("full_pl_ready", 32'(mv.pl_ready), 32'd0);
        checkOutput("full_pc_ready", 32'(mv.pc_ready), 32'd0);
        mv.pl_valid = 1'b1;
        mv.pl_en    = 16'h0001;
        mv.pc_valid = 1'b1;
        mv.pc_en    = 16'h0002;
        repeat (4) @(negedge clock);
        checkOutput("full_ready_held", 32'(mv.pl_ready | mv.pc_ready), 32'd0);
        checkOutput("full_board_kept", board, modelBoard);
        checkOutput("full_move_count", 32'(move_count), 32'd16);
        mv.pl_valid = 1'b0;
        mv.pl_en    = '0;
        mv.pc_valid = 1'b0;
        mv.pc_en    = '0;

        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        @(negedge clock);
        checkOutput("newgame_board", board, 32'd0);
        checkOutput("newgame_move_count", 32'(move_count), 32'd0);
        checkOutput("newgame_turn", 32'(turn), 32'd0);
        checkOutput("newgame_board_full", 32'(board_full), 32'd0);
        checkOutput("newgame_pl_ready", 32'(mv.pl_ready), 32'd1);

        v = '{1'b1, 16'h0001, 1'b0, 16'h0000, 1'b1, 3'd0, 32'h0000_0001, 1'b1, 5'd1};
        applyStimulus(v, 1'b0);

        // Asynchronous reset while a computer move sits in the check stage.
        @(negedge clock);
        mv.pc_valid = 1'b1;
        mv.pc_en    = 16'h0002;
        @(posedge clock);
        @(negedge clock);
        mv.pc_valid = 1'b0;
        mv.pc_en    = '0;
        reset_n     = 1'b0;
        #1;
`ifdef MOVE_VALIDATOR_ILLEGAL_CNT_EN
        tbIllCnt = 0;
`endif
        checkOutput("midrst_board", board, 32'd0);
        checkOutput("midrst_turn", 32'(turn), 32'd0);
        checkOutput("midrst_move_count", 32'(move_count), 32'd0);
        checkOutput("midrst_move_ok", 32'(move_ok), 32'd0);
        checkOutput("midrst_pl_ready", 32'(mv.pl_ready), 32'd1);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        checkOutput("postrst_board", board, 32'd0);
        checkOutput("postrst_move_count", 32'(move_count), 32'd0);
        checkOutput("postrst_board_full", 32'(board_full), 32'd0);
`ifdef MOVE_VALIDATOR_ILLEGAL_CNT_EN
        checkOutput("postrst_illegal_cnt", 32'(illegal_cnt), 32'd0);
`endif

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
